// File: rtl/pll_lock_reset_sequencer.sv
// PLL start-up/supervision: drives RESETB/BYPASS, qualifies LOCK,
// releases downstream resets in stages and re-sequences on lock loss.
module pll_lock_reset_sequencer #(
  parameter int RESET_ASSERT_CYCLES = 16,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int NUM_DOMAINS         = 2,
  parameter int STAGE_DELAY_CYCLES  = 16,
  parameter int MAX_RETRIES         = 3,
  parameter int BYPASS_ON_FAIL      = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pll_lock,
  input  logic                   force_relock,
  output logic                   pll_resetb,
  output logic                   pll_bypass,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   ready,
  output logic                   failed,
  output logic [(MAX_RETRIES > 0 ? $clog2(MAX_RETRIES+1) : 1)-1:0]
                                 retry_count,
  output logic [7:0]             lock_loss_count
);

  localparam int RW  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES+1) : 1;
  localparam int REL = STAGE_DELAY_CYCLES * NUM_DOMAINS;
  localparam int M1  = (RESET_ASSERT_CYCLES > LOCK_STABLE_CYCLES) ?
                       RESET_ASSERT_CYCLES : LOCK_STABLE_CYCLES;
  localparam int M2  = (M1 > LOCK_TIMEOUT_CYCLES) ? M1 : LOCK_TIMEOUT_CYCLES;
  localparam int MX  = (M2 > REL) ? M2 : REL;
  localparam int CW  = $clog2(MX + 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT,
    S_REL,
    S_RUN,
    S_FAIL
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_n;
  logic [CW-1:0]          stable_q, stable_d, stable_n;
  logic [RW-1:0]          retry_q, retry_d;
  logic [7:0]             llc_q, llc_d;
  logic                   resetb_q, resetb_d;
  logic                   bypass_q, bypass_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic                   failed_q, failed_d;
  logic [1:0]             sync_q;
  logic                   lock_s;

  assign lock_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      stable_q <= '0;
      retry_q  <= '0;
      llc_q    <= '0;
      resetb_q <= 1'b0;
      bypass_q <= 1'b0;
      dom_q    <= '1;
      ready_q  <= 1'b0;
      failed_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], pll_lock};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      retry_q  <= retry_d;
      llc_q    <= llc_d;
      resetb_q <= resetb_d;
      bypass_q <= bypass_d;
      dom_q    <= dom_d;
      ready_q  <= ready_d;
      failed_q <= failed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    retry_d  = retry_q;
    llc_d    = llc_q;
    resetb_d = resetb_q;
    bypass_d = bypass_q;
    dom_d    = dom_q;
    ready_d  = ready_q;
    failed_d = failed_q;
    cnt_n    = cnt_q + CW'(1);
    stable_n = lock_s ? stable_q + CW'(1) : '0;

    unique case (state_q)
      S_HOLD: begin
        resetb_d = 1'b0;
        dom_d    = '1;
        if (cnt_q == CW'(RESET_ASSERT_CYCLES - 1)) begin
          state_d  = S_WAIT;
          cnt_d    = '0;
          stable_d = '0;
          resetb_d = 1'b1;
        end else begin
          cnt_d = cnt_n;
        end
      end
      S_WAIT: begin
        // a stable lock wins over a coincident timeout
        if (stable_n == CW'(LOCK_STABLE_CYCLES)) begin
          state_d  = S_REL;
          cnt_d    = '0;
          stable_d = '0;
        end else if (cnt_n == CW'(LOCK_TIMEOUT_CYCLES)) begin
          cnt_d    = '0;
          stable_d = '0;
          resetb_d = 1'b0;
          if (retry_q < RW'(MAX_RETRIES)) begin
            state_d = S_HOLD;
            retry_d = retry_q + RW'(1);
          end else begin
            state_d  = S_FAIL;
            failed_d = 1'b1;
            ready_d  = 1'b0;
            bypass_d = (BYPASS_ON_FAIL != 0);
            dom_d    = (BYPASS_ON_FAIL != 0) ? '0 : '1;
          end
        end else begin
          cnt_d    = cnt_n;
          stable_d = stable_n;
        end
      end
      S_REL, S_RUN: begin
        if (!lock_s) begin
          state_d  = S_HOLD;
          cnt_d    = '0;
          stable_d = '0;
          resetb_d = 1'b0;
          dom_d    = '1;
          ready_d  = 1'b0;
          if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
        end else if (state_q == S_REL) begin
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (cnt_q == CW'(STAGE_DELAY_CYCLES * (i + 1) - 1))
              dom_d[i] = 1'b0;
          end
          if (cnt_q == CW'(REL - 1)) begin
            state_d = S_RUN;
            cnt_d   = '0;
            dom_d   = '0;
            ready_d = 1'b1;
            retry_d = '0;
          end else begin
            cnt_d = cnt_n;
          end
        end
      end
      S_FAIL: begin
        resetb_d = 1'b0;
        ready_d  = 1'b0;
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase

    if (force_relock) begin
      state_d  = S_HOLD;
      cnt_d    = '0;
      stable_d = '0;
      retry_d  = '0;
      resetb_d = 1'b0;
      bypass_d = 1'b0;
      dom_d    = '1;
      ready_d  = 1'b0;
      failed_d = 1'b0;
    end
  end

  assign pll_resetb      = resetb_q;
  assign pll_bypass      = bypass_q;
  assign domain_reset    = dom_q;
  assign ready           = ready_q;
  assign failed          = failed_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Directed bench for pll_lock_reset_sequencer with small parameters:
// hand-timed lock/relock/fail/force/saturation scenarios.
module tb_pll_lock_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       force_relock;
  logic       pll_resetb;
  logic       pll_bypass;
  logic [2:0] domain_reset;
  logic       ready;
  logic       failed;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pll_lock_reset_sequencer #(
    .RESET_ASSERT_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(64),
    .NUM_DOMAINS(3),
    .STAGE_DELAY_CYCLES(5),
    .MAX_RETRIES(2),
    .BYPASS_ON_FAIL(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pll_lock(pll_lock),
    .force_relock(force_relock),
    .pll_resetb(pll_resetb),
    .pll_bypass(pll_bypass),
    .domain_reset(domain_reset),
    .ready(ready),
    .failed(failed),
    .retry_count(retry_count),
    .lock_loss_count(lock_loss_count)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pll_lock = 1'b0;
    force_relock = 1'b0;
    step(2);
    vecs++; if (pll_resetb !== 1'b0) begin errs++; $display("FAIL rst_resetb got %b want 0", pll_resetb); end
    vecs++; if (pll_bypass !== 1'b0) begin errs++; $display("FAIL rst_bypass got %b want 0", pll_bypass); end
    vecs++; if (domain_reset !== 3'b111) begin errs++; $display("FAIL rst_dom got %b want 111", domain_reset); end
    vecs++; if (ready !== 1'b0 || failed !== 1'b0) begin errs++; $display("FAIL rst_rdy_fail got %b%b want 00", ready, failed); end
    vecs++; if (retry_count !== 2'd0 || lock_loss_count !== 8'd0) begin errs++; $display("FAIL rst_cnts got %0d/%0d want 0/0", retry_count, lock_loss_count); end
  endtask

  task automatic test_clean_lock;
    reset = 1'b0;
    step(3);
    vecs++; if (pll_resetb !== 1'b0) begin errs++; $display("FAIL clean_hold got %b want 0", pll_resetb); end
    step(1);
    vecs++; if (pll_resetb !== 1'b1) begin errs++; $display("FAIL clean_resetb_rise got %b want 1", pll_resetb); end
    step(10);
    pll_lock = 1'b1;
    step(14);
    vecs++; if (domain_reset !== 3'b111) begin errs++; $display("FAIL clean_pre_d0 got %b want 111", domain_reset); end
    step(1);
    vecs++; if (domain_reset !== 3'b110) begin errs++; $display("FAIL clean_d0 got %b want 110", domain_reset); end
    step(5);
    vecs++; if (domain_reset !== 3'b100) begin errs++; $display("FAIL clean_d1 got %b want 100", domain_reset); end
    step(4);
    vecs++; if (ready !== 1'b0 || domain_reset !== 3'b100) begin errs++; $display("FAIL clean_pre_d2 got rdy=%b dom=%b want 0/100", ready, domain_reset); end
    step(1);
    vecs++; if (domain_reset !== 3'b000 || ready !== 1'b1) begin errs++; $display("FAIL clean_run got dom=%b rdy=%b want 000/1", domain_reset, ready); end
    vecs++; if (retry_count !== 2'd0) begin errs++; $display("FAIL clean_retry got %0d want 0", retry_count); end
  endtask

  task automatic test_lock_loss;
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(1);
    vecs++; if (domain_reset !== 3'b000 || ready !== 1'b1) begin errs++; $display("FAIL loss_early got dom=%b rdy=%b want 000/1", domain_reset, ready); end
    step(1);
    vecs++; if (domain_reset !== 3'b111 || ready !== 1'b0) begin errs++; $display("FAIL loss_dom got dom=%b rdy=%b want 111/0", domain_reset, ready); end
    vecs++; if (lock_loss_count !== 8'd1 || pll_resetb !== 1'b0) begin errs++; $display("FAIL loss_llc got llc=%0d rb=%b want 1/0", lock_loss_count, pll_resetb); end
    step(3);
    vecs++; if (pll_resetb !== 1'b0) begin errs++; $display("FAIL loss_hold got %b want 0", pll_resetb); end
    step(1);
    vecs++; if (pll_resetb !== 1'b1) begin errs++; $display("FAIL loss_rb_rise got %b want 1", pll_resetb); end
    step(12);
    vecs++; if (domain_reset !== 3'b111) begin errs++; $display("FAIL loss_pre_d0 got %b want 111", domain_reset); end
    step(1);
    vecs++; if (domain_reset !== 3'b110) begin errs++; $display("FAIL loss_d0 got %b want 110", domain_reset); end
    step(5);
    vecs++; if (domain_reset !== 3'b100) begin errs++; $display("FAIL loss_d1 got %b want 100", domain_reset); end
    step(5);
    vecs++; if (domain_reset !== 3'b000 || ready !== 1'b1) begin errs++; $display("FAIL loss_run got dom=%b rdy=%b want 000/1", domain_reset, ready); end
    vecs++; if (lock_loss_count !== 8'd1) begin errs++; $display("FAIL loss_llc_keep got %0d want 1", lock_loss_count); end
  endtask

  task automatic test_glitchy_lock;
    pll_lock = 1'b0;
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    step(4);
    vecs++; if (pll_resetb !== 1'b1) begin errs++; $display("FAIL glitch_rb got %b want 1", pll_resetb); end
    pll_lock = 1'b1;
    step(6);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(8);
    vecs++; if (domain_reset !== 3'b111) begin errs++; $display("FAIL glitch_early got %b want 111", domain_reset); end
    step(6);
    vecs++; if (domain_reset !== 3'b111) begin errs++; $display("FAIL glitch_pre_d0 got %b want 111", domain_reset); end
    step(1);
    vecs++; if (domain_reset !== 3'b110) begin errs++; $display("FAIL glitch_d0 got %b want 110", domain_reset); end
    step(10);
    vecs++; if (domain_reset !== 3'b000 || ready !== 1'b1) begin errs++; $display("FAIL glitch_run got dom=%b rdy=%b want 000/1", domain_reset, ready); end
  endtask

  task automatic test_never_lock;
    pll_lock = 1'b0;
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    vecs++; if (retry_count !== 2'd0) begin errs++; $display("FAIL nl_start got %0d want 0", retry_count); end
    step(67);
    vecs++; if (retry_count !== 2'd0 || pll_resetb !== 1'b1) begin errs++; $display("FAIL nl_a1 got rc=%0d rb=%b want 0/1", retry_count, pll_resetb); end
    step(1);
    vecs++; if (retry_count !== 2'd1 || pll_resetb !== 1'b0) begin errs++; $display("FAIL nl_retry1 got rc=%0d rb=%b want 1/0", retry_count, pll_resetb); end
    step(67);
    vecs++; if (retry_count !== 2'd1) begin errs++; $display("FAIL nl_a2 got %0d want 1", retry_count); end
    step(1);
    vecs++; if (retry_count !== 2'd2 || pll_resetb !== 1'b0) begin errs++; $display("FAIL nl_retry2 got rc=%0d rb=%b want 2/0", retry_count, pll_resetb); end
    step(67);
    vecs++; if (failed !== 1'b0 || pll_resetb !== 1'b1) begin errs++; $display("FAIL nl_a3 got f=%b rb=%b want 0/1", failed, pll_resetb); end
    step(1);
    vecs++; if (failed !== 1'b1 || pll_bypass !== 1'b1) begin errs++; $display("FAIL nl_fail got f=%b byp=%b want 1/1", failed, pll_bypass); end
    vecs++; if (pll_resetb !== 1'b0 || domain_reset !== 3'b000 || ready !== 1'b0) begin errs++; $display("FAIL nl_fail_out got rb=%b dom=%b rdy=%b want 0/000/0", pll_resetb, domain_reset, ready); end
    pll_lock = 1'b1;
    step(20);
    pll_lock = 1'b0;
    step(5);
    vecs++; if (failed !== 1'b1 || domain_reset !== 3'b000 || pll_bypass !== 1'b1) begin errs++; $display("FAIL nl_sticky got f=%b dom=%b byp=%b want 1/000/1", failed, domain_reset, pll_bypass); end
  endtask

  task automatic test_force_relock;
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    vecs++; if (domain_reset !== 3'b111 || failed !== 1'b0 || pll_bypass !== 1'b0) begin errs++; $display("FAIL frc_fail got dom=%b f=%b byp=%b want 111/0/0", domain_reset, failed, pll_bypass); end
    vecs++; if (retry_count !== 2'd0 || lock_loss_count !== 8'd1 || pll_resetb !== 1'b0) begin errs++; $display("FAIL frc_fail_cnt got rc=%0d llc=%0d rb=%b want 0/1/0", retry_count, lock_loss_count, pll_resetb); end
    step(4);
    pll_lock = 1'b1;
    step(15);
    vecs++; if (domain_reset !== 3'b110) begin errs++; $display("FAIL frc_rel_d0 got %b want 110", domain_reset); end
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    vecs++; if (domain_reset !== 3'b111 || ready !== 1'b0 || pll_resetb !== 1'b0) begin errs++; $display("FAIL frc_rel got dom=%b rdy=%b rb=%b want 111/0/0", domain_reset, ready, pll_resetb); end
    vecs++; if (lock_loss_count !== 8'd1 || failed !== 1'b0) begin errs++; $display("FAIL frc_rel_llc got llc=%0d f=%b want 1/0", lock_loss_count, failed); end
    step(3);
    vecs++; if (pll_resetb !== 1'b0) begin errs++; $display("FAIL frc_hold got %b want 0", pll_resetb); end
    step(1);
    vecs++; if (pll_resetb !== 1'b1) begin errs++; $display("FAIL frc_rb_rise got %b want 1", pll_resetb); end
    step(23);
    vecs++; if (domain_reset !== 3'b000 || ready !== 1'b1) begin errs++; $display("FAIL frc_run got dom=%b rdy=%b want 000/1", domain_reset, ready); end
  endtask

  task automatic test_reset_mid_run;
    reset = 1'b1;
    step(1);
    vecs++; if (domain_reset !== 3'b111 || ready !== 1'b0 || pll_resetb !== 1'b0) begin errs++; $display("FAIL rrun_out got dom=%b rdy=%b rb=%b want 111/0/0", domain_reset, ready, pll_resetb); end
    vecs++; if (lock_loss_count !== 8'd0 || failed !== 1'b0 || pll_bypass !== 1'b0) begin errs++; $display("FAIL rrun_cnt got llc=%0d f=%b byp=%b want 0/0/0", lock_loss_count, failed, pll_bypass); end
  endtask

  task automatic test_saturation;
    int k;
    pll_lock = 1'b1;
    step(1);
    reset = 1'b0;
    for (int n = 1; n <= 260; n++) begin
      k = 0;
      while (pll_resetb !== 1'b1 && k < 40) begin step(1); k++; end
      if (pll_resetb !== 1'b1) begin
        vecs++; errs++;
        $display("FAIL sat_wait_rise iter %0d rb=%b want 1", n, pll_resetb);
        break;
      end
      step(6);
      pll_lock = 1'b0;
      step(1);
      pll_lock = 1'b1;
      k = 0;
      while (pll_resetb !== 1'b0 && k < 40) begin step(1); k++; end
      if (pll_resetb !== 1'b0) begin
        vecs++; errs++;
        $display("FAIL sat_wait_fall iter %0d rb=%b want 0", n, pll_resetb);
        break;
      end
      if (n == 1 || n == 255) begin
        vecs++; if (lock_loss_count !== 8'(n)) begin errs++; $display("FAIL sat_iter%0d got %0d want %0d", n, lock_loss_count, n); end
      end
    end
    vecs++; if (lock_loss_count !== 8'd255) begin errs++; $display("FAIL sat_final got %0d want 255", lock_loss_count); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_lock_loss();
    test_glitchy_lock();
    test_never_lock();
    test_force_relock();
    test_reset_mid_run();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
